// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus between the command-port initiator and a register-file slave.
// The master modport is the initiator side; the slave modport is the target side.
interface axi_lite_master_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;
    logic [ADDR_WIDTH-1:0]   m_axi_araddr;
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;
    logic [DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]              m_axi_rresp;
    logic                    m_axi_rvalid;
    logic                    m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns a request/response command port
// into AXI4-Lite reads and writes for the NPU control register file.
// Optional watchdog: define AXIL_MST_TIMEOUT_EN to abort a stalled transaction
// after TIMEOUT_CYCLES cycles in one bus state, reporting rsp_resp = 2'b11.
module axi_lite_master #(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        rsp_err,
    axi_lite_master_if.master           m_axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic                        req_ready_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic                        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                        aw_done_q, w_done_q;
    logic                        rsp_valid_q;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]                  rsp_resp_q;
    logic                        aw_hs, w_hs, busy, timeout;

    assign aw_hs = awvalid_q && m_axi.m_axi_awready;
    assign w_hs  = wvalid_q && m_axi.m_axi_wready;
    assign busy  = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                   (state_q == RD_REQ) || (state_q == RD_RESP);

`ifdef AXIL_MST_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q, timer_d;

    assign timer_d = timer_q + 1'b1;
    assign timeout = busy && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts cycles spent in one bus state and restarts on every state change
    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) begin
            timer_q <= '0;
        end else if (busy) begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state decode; write leaves WR_REQ once both AW and W have handshaken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid && req_ready_q) state_d = req_write ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
            WR_RESP: if (bready_q && m_axi.m_axi_bvalid) state_d = DONE;
            RD_REQ:  if (arvalid_q && m_axi.m_axi_arready) state_d = RD_RESP;
            RD_RESP: if (rready_q && m_axi.m_axi_rvalid) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = DONE;
    end

    // Transaction FSM with every bus and response output held in a register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                        if (req_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            arvalid_q <= 1'b1;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (state_d == WR_RESP) bready_q <= 1'b1;
                end
                WR_RESP: begin
                    if (bready_q && m_axi.m_axi_bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= m_axi.m_axi_bresp;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (arvalid_q && m_axi.m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (rready_q && m_axi.m_axi_rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= m_axi.m_axi_rdata;
                        rsp_resp_q  <= m_axi.m_axi_rresp;
                        rsp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (timeout) begin
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_resp_q  <= 2'b11;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign req_ready           = req_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign rsp_resp            = rsp_resp_q;
    assign rsp_err             = (rsp_resp_q != 2'b00);
    assign m_axi.m_axi_awaddr  = addr_q;
    assign m_axi.m_axi_awvalid = awvalid_q;
    assign m_axi.m_axi_wdata   = wdata_q;
    assign m_axi.m_axi_wstrb   = wstrb_q;
    assign m_axi.m_axi_wvalid  = wvalid_q;
    assign m_axi.m_axi_bready  = bready_q;
    assign m_axi.m_axi_araddr  = addr_q;
    assign m_axi.m_axi_arvalid = arvalid_q;
    assign m_axi.m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: table of directed transactions against
// a configurable-latency AXI4-Lite slave model, plus hand-written corner sequences.
// Define AXIL_MST_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 16).
module tb_axi_lite_master;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          awD;
        int          wD;
        int          bD;
        int          arD;
        int          rD;
        logic [31:0] slvRdata;
        logic [1:0]  slvResp;
        logic [31:0] expRdata;
        logic [1:0]  expResp;
        logic        expErr;
        int          expLat;
        int          expAw;
        int          expW;
        int          expAr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_wstrb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    int checks = 0;
    int errors = 0;

    axi_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_lite_master #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .rsp_err(rsp_err),
        .m_axi(axi.master)
    );

    always #5 clk = ~clk;

    // Slave model configuration, set by the test before each request
    int          cfgAwDelay = 0, cfgWDelay = 0, cfgBDelay = 0, cfgArDelay = 0, cfgRDelay = 0;
    logic        cfgArNever = 1'b0;
    logic [31:0] cfgRdata = '0;
    logic [1:0]  cfgResp = 2'b00;
    logic        strayB = 1'b0;

    logic        slvBvalid, awGot, wGot, bArm, rArm;
    int          awCnt, wCnt, arCnt, bCnt, rCnt;
    int          bCount = 0;
    logic [11:0] capAwaddr, capAraddr;
    logic [31:0] capWdata;
    logic [3:0]  capWstrb;
    logic        hsAw, hsW, hsAr;

    assign hsAw = axi.m_axi_awvalid && axi.m_axi_awready;
    assign hsW  = axi.m_axi_wvalid && axi.m_axi_wready;
    assign hsAr = axi.m_axi_arvalid && axi.m_axi_arready;
    assign axi.m_axi_bvalid = slvBvalid | strayB;

    // AXI4-Lite slave: readies after a programmable wait, responses after a programmable delay
    always @(posedge clk) begin
        if (rst) begin
            axi.m_axi_awready <= 1'b0;
            axi.m_axi_wready  <= 1'b0;
            axi.m_axi_arready <= 1'b0;
            axi.m_axi_rvalid  <= 1'b0;
            axi.m_axi_bresp   <= 2'b00;
            axi.m_axi_rresp   <= 2'b00;
            axi.m_axi_rdata   <= '0;
            slvBvalid <= 1'b0;
            awGot <= 1'b0; wGot <= 1'b0; bArm <= 1'b0; rArm <= 1'b0;
            awCnt <= 0; wCnt <= 0; arCnt <= 0; bCnt <= 0; rCnt <= 0;
        end else begin
            if (!axi.m_axi_awvalid || hsAw) begin
                awCnt <= 0;
                axi.m_axi_awready <= (cfgAwDelay == 0);
            end else begin
                awCnt <= awCnt + 1;
                if (awCnt + 1 >= cfgAwDelay) axi.m_axi_awready <= 1'b1;
            end
            if (!axi.m_axi_wvalid || hsW) begin
                wCnt <= 0;
                axi.m_axi_wready <= (cfgWDelay == 0);
            end else begin
                wCnt <= wCnt + 1;
                if (wCnt + 1 >= cfgWDelay) axi.m_axi_wready <= 1'b1;
            end
            if (!axi.m_axi_arvalid || hsAr) begin
                arCnt <= 0;
                axi.m_axi_arready <= !cfgArNever && (cfgArDelay == 0);
            end else begin
                arCnt <= arCnt + 1;
                if (!cfgArNever && (arCnt + 1 >= cfgArDelay)) axi.m_axi_arready <= 1'b1;
            end
            if (hsAw) capAwaddr <= axi.m_axi_awaddr;
            if (hsW) begin
                capWdata <= axi.m_axi_wdata;
                capWstrb <= axi.m_axi_wstrb;
            end
            if ((awGot || hsAw) && (wGot || hsW)) begin
                awGot <= 1'b0;
                wGot  <= 1'b0;
                if (cfgBDelay == 0) begin
                    slvBvalid <= 1'b1;
                    axi.m_axi_bresp <= cfgResp;
                end else begin
                    bArm <= 1'b1;
                    bCnt <= cfgBDelay - 1;
                end
            end else begin
                if (hsAw) awGot <= 1'b1;
                if (hsW) wGot <= 1'b1;
            end
            if (bArm) begin
                if (bCnt == 0) begin
                    slvBvalid <= 1'b1;
                    axi.m_axi_bresp <= cfgResp;
                    bArm <= 1'b0;
                end else begin
                    bCnt <= bCnt - 1;
                end
            end
            if (slvBvalid && axi.m_axi_bready) begin
                slvBvalid <= 1'b0;
                bCount <= bCount + 1;
            end
            if (hsAr) begin
                capAraddr <= axi.m_axi_araddr;
                if (cfgRDelay == 0) begin
                    axi.m_axi_rvalid <= 1'b1;
                    axi.m_axi_rdata  <= cfgRdata;
                    axi.m_axi_rresp  <= cfgResp;
                end else begin
                    rArm <= 1'b1;
                    rCnt <= cfgRDelay - 1;
                end
            end
            if (rArm) begin
                if (rCnt == 0) begin
                    axi.m_axi_rvalid <= 1'b1;
                    axi.m_axi_rdata  <= cfgRdata;
                    axi.m_axi_rresp  <= cfgResp;
                    rArm <= 1'b0;
                end else begin
                    rCnt <= rCnt - 1;
                end
            end
            if (axi.m_axi_rvalid && axi.m_axi_rready) axi.m_axi_rvalid <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ctl outputs"}, {27'd0, req_ready, rsp_valid, rsp_err, rsp_resp}, 32'd0);
        checkOutput({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        checkOutput({tag, " axi valid/ready"}, {27'd0, axi.m_axi_awvalid, axi.m_axi_wvalid,
                    axi.m_axi_bready, axi.m_axi_arvalid, axi.m_axi_rready}, 32'd0);
        checkOutput({tag, " awaddr"}, {20'd0, axi.m_axi_awaddr}, 32'd0);
        checkOutput({tag, " araddr"}, {20'd0, axi.m_axi_araddr}, 32'd0);
        checkOutput({tag, " wdata"}, axi.m_axi_wdata, 32'd0);
        checkOutput({tag, " wstrb"}, {28'd0, axi.m_axi_wstrb}, 32'd0);
    endtask

    // Issue one request (called at a negedge) and wait for rsp_valid; returns the cycle it appeared
    task automatic applyStimulus(input vec_t v, output int lat, output int awC, output int wC, output int arC);
        logic done;
        cfgAwDelay = v.awD; cfgWDelay = v.wD; cfgBDelay = v.bD;
        cfgArDelay = v.arD; cfgRDelay = v.rD;
        cfgRdata = v.slvRdata; cfgResp = v.slvResp;
        req_write = v.write; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        req_valid = 1'b1;
        lat = 0; awC = 0; wC = 0; arC = 0; done = 1'b0;
        for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
        if (!req_ready) checkOutput("req_ready wait", {31'd0, req_ready}, 32'd1);
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (axi.m_axi_awvalid) awC++;
            if (axi.m_axi_wvalid) wC++;
            if (axi.m_axi_arvalid) arC++;
            if (rsp_valid) begin
                lat = c;
                done = 1'b1;
            end
        end
        if (!done) checkOutput("rsp_valid wait", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic releaseRsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({tag, " rsp_valid after ready"}, {31'd0, rsp_valid}, 32'd0);
        checkOutput({tag, " req_ready after ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int lat, awC, wC, arC, bStart;
        bStart = bCount;
        applyStimulus(v, lat, awC, wC, arC);
        checkOutput({tag, " latency"}, lat, v.expLat);
        checkOutput({tag, " rsp_rdata"}, rsp_rdata, v.expRdata);
        checkOutput({tag, " rsp_resp"}, {30'd0, rsp_resp}, {30'd0, v.expResp});
        checkOutput({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, v.expErr});
        checkOutput({tag, " awvalid cycles"}, awC, v.expAw);
        checkOutput({tag, " wvalid cycles"}, wC, v.expW);
        checkOutput({tag, " arvalid cycles"}, arC, v.expAr);
        checkOutput({tag, " B accepted"}, bCount - bStart, v.write ? 1 : 0);
        if (v.write) begin
            checkOutput({tag, " awaddr"}, {20'd0, capAwaddr}, {20'd0, v.addr});
            checkOutput({tag, " wdata"}, capWdata, v.wdata);
            checkOutput({tag, " wstrb"}, {28'd0, capWstrb}, {28'd0, v.wstrb});
        end else begin
            checkOutput({tag, " araddr"}, {20'd0, capAraddr}, {20'd0, v.addr});
        end
        releaseRsp(tag);
    endtask

    vec_t vecs[7];
    vec_t holdVec, postRstVec;

    initial begin
        int lat, awC, wC, arC, bBefore;
        //            wr    addr     wdata          strb awD wD bD arD rD slvRdata       rsp    expRdata       resp   err lat aw w ar
        vecs[0] = '{1'b1, 12'h008, 32'h0000_000F, 4'hF, 0, 0, 0, 0, 0, 32'h0,          2'b00, 32'h0,          2'b00, 1'b0, 3, 1, 1, 0};
        vecs[1] = '{1'b0, 12'h004, 32'h0,         4'h0, 0, 0, 0, 0, 4, 32'h0000_0005, 2'b00, 32'h0000_0005, 2'b00, 1'b0, 7, 0, 0, 1};
        vecs[2] = '{1'b1, 12'h01C, 32'hDEAD_BEEF, 4'h3, 1, 5, 0, 0, 0, 32'h0,          2'b00, 32'h0,          2'b00, 1'b0, 8, 2, 6, 0};
        vecs[3] = '{1'b0, 12'h010, 32'h0,         4'h0, 0, 0, 0, 2, 1, 32'hA5A5_0001, 2'b10, 32'hA5A5_0001, 2'b10, 1'b1, 6, 0, 0, 3};
        vecs[4] = '{1'b1, 12'h014, 32'h1234_5678, 4'hC, 0, 0, 2, 0, 0, 32'h0,          2'b10, 32'h0,          2'b10, 1'b1, 5, 1, 1, 0};
        vecs[5] = '{1'b0, 12'h018, 32'h0,         4'h0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 2'b01, 32'hCAFE_F00D, 2'b01, 1'b1, 3, 0, 0, 1};
        vecs[6] = '{1'b1, 12'h000, 32'hFFFF_FFFF, 4'h0, 3, 0, 0, 0, 0, 32'h0,          2'b00, 32'h0,          2'b00, 1'b0, 6, 4, 1, 0};
        holdVec    = '{1'b0, 12'h00C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0BAD_0BAD, 2'b10, 32'h0BAD_0BAD, 2'b10, 1'b1, 3, 0, 0, 1};
        postRstVec = '{1'b0, 12'h000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0000_0001, 2'b00, 32'h0000_0001, 2'b00, 1'b0, 3, 0, 0, 1};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset req_ready rises", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 7; i++) runVector(vecs[i], $sformatf("vec%0d", i));

        $display("[TB] stray B response while idle");
        strayB = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stray B bready", {31'd0, axi.m_axi_bready}, 32'd0);
            checkOutput("stray B rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        strayB = 1'b0;
        @(negedge clk);

        $display("[TB] SLVERR read held with rsp_ready low");
        applyStimulus(holdVec, lat, awC, wC, arC);
        checkOutput("hold latency", lat, 3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("hold rsp_rdata", rsp_rdata, 32'h0BAD_0BAD);
            checkOutput("hold err/resp", {29'd0, rsp_err, rsp_resp}, 32'b110);
            checkOutput("hold req_ready", {31'd0, req_ready}, 32'd0);
        end
        releaseRsp("hold");

        $display("[TB] reset during WR_RESP");
        cfgAwDelay = 0; cfgWDelay = 0; cfgBDelay = 20; cfgResp = 2'b00;
        req_write = 1'b1; req_addr = 12'h020; req_wdata = 32'h1111_2222; req_wstrb = 4'hF;
        req_valid = 1'b1;
        for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 20 && !axi.m_axi_bready; c++) @(negedge clk);
        checkOutput("mid-rst reached WR_RESP", {31'd0, axi.m_axi_bready}, 32'd1);
        bBefore = bCount;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("mid-rst");
        @(negedge clk);
        checkOutput("mid-rst req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("mid-rst no B accepted", bCount - bBefore, 32'd0);
        runVector(postRstVec, "post-rst read");

`ifdef AXIL_MST_TIMEOUT_EN
        $display("[TB] watchdog on a slave that never accepts AR");
        cfgArNever = 1'b1;
        applyStimulus(postRstVec, lat, awC, wC, arC);
        checkOutput("timeout latency", lat, 17);
        checkOutput("timeout arvalid cycles", arC, 16);
        checkOutput("timeout arvalid low", {31'd0, axi.m_axi_arvalid}, 32'd0);
        checkOutput("timeout rsp_resp", {30'd0, rsp_resp}, 32'd3);
        checkOutput("timeout rsp_err", {31'd0, rsp_err}, 32'd1);
        checkOutput("timeout rsp_rdata", rsp_rdata, 32'd0);
        releaseRsp("timeout");
        cfgArNever = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard ceiling so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL global timeout: actual running required finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
